// File: rtl/sc_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-empty/almost-full thresholds,
// synchronous flush and sticky overflow/underflow flags. Define SC_FIFO_FWFT_EN for first-word-fall-through.
module sc_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [ADDR_SIZE:0]    ae_level,
  input  logic [ADDR_SIZE:0]    af_level,
  output logic [DATA_WIDTH-1:0] out,
  output logic [ADDR_SIZE:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] ONE_C   = {{ADDR_SIZE{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_SIZE:0]    w_ptr_q, w_ptr_d;
  logic [ADDR_SIZE:0]    r_ptr_q, r_ptr_d;
  logic [ADDR_SIZE:0]    count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [ADDR_SIZE-1:0]  w_addr, r_addr;

  assign w_addr = w_ptr_q[ADDR_SIZE-1:0];
  assign r_addr = r_ptr_q[ADDR_SIZE-1:0];

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign count        = count_q;
  assign almost_empty = (count_q <= ae_level);
  assign almost_full  = (count_q >= af_level);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Accept decisions use pre-edge full/empty, so a full FIFO still pops and an empty one still pushes.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + ONE_C;
      if (rd_acc) r_ptr_d = r_ptr_q + ONE_C;
      if (w_en && full)  ovf_d = 1'b1;
      if (r_en && empty) udf_d = 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is never reset or flushed; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) mem_q[w_addr] <= w_data;
  end

`ifdef SC_FIFO_FWFT_EN
  assign out = mem_q[r_addr];
`else
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (clr) begin
      out_q <= '0;
    end else if (rd_acc) begin
      out_q <= mem_q[r_addr];
    end
  end

  assign out = out_q;
`endif

endmodule
